// File: rtl/seq_detector_pkg.sv
// Shared types and active-low 7-segment codes for the parametrised sequence detector.
package seq_detector_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        GAP  = 1'b1
    } state_e;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp held off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seq_detector_param_if.sv
// Data, control and display signals of the sequence detector.
interface seq_detector_param_if #(
    parameter int unsigned DIGITS = 2
) ();

    logic                  ena;
    logic                  sig_to_test;
    logic                  overlap;
    logic                  clr_count;
    logic                  z;
    logic [4*DIGITS-1:0]   count_detect;
    logic [8*DIGITS-1:0]   disp;

    modport master (
        output ena, sig_to_test, overlap, clr_count,
        input  z, count_detect, disp
    );

    modport slave (
        input  ena, sig_to_test, overlap, clr_count,
        output z, count_detect, disp
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// One BCD digit to active-low segments; codes A-F show blank.
module bcd_to_7seg
    import seq_detector_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seq_detector_param.sv
// Detects PREFIX, a bounded run of zeros, then a 1; counts detects in BCD and drives 7-seg.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int unsigned              PREFIX_LEN = 2,
    parameter logic [PREFIX_LEN-1:0]    PREFIX     = 2'b01,
    parameter int unsigned              MIN_ZEROS  = 0,
    parameter int unsigned              MAX_ZEROS  = 15,
    parameter int unsigned              DIGITS     = 2,
    parameter bit                       SATURATE   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);

    localparam int unsigned ZW    = (MAX_ZEROS > 0) ? $clog2(MAX_ZEROS + 1) : 1;
    localparam int unsigned VW    = $clog2(PREFIX_LEN + 1);
    localparam int unsigned CW    = 4 * DIGITS;
    localparam logic [VW-1:0] VFULL = VW'(PREFIX_LEN);

    state_e                 state_q, state_d;
    logic [PREFIX_LEN-1:0]  hist_q, hist_d, hist_new;
    logic [PREFIX_LEN:0]    hist_ext;
    logic [VW-1:0]          valid_q, valid_d, valid_new;
    logic [ZW-1:0]          zcnt_q, zcnt_d;
    logic [CW-1:0]          count_q, count_d, count_inc;
    logic                   z_q;
    logic                   prefix_hit;
    logic                   detect;
    logic                   carry;
    logic                   all_nines;

    assign hist_ext   = {hist_q, bus.sig_to_test};
    assign hist_new   = hist_ext[PREFIX_LEN-1:0];
    assign valid_new  = (valid_q == VFULL) ? valid_q : valid_q + 1'b1;
    assign prefix_hit = (valid_new == VFULL) && (hist_new == PREFIX);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        valid_d = valid_q;
        zcnt_d  = zcnt_q;
        detect  = 1'b0;
        if (bus.ena) begin
            hist_d  = hist_new;
            valid_d = valid_new;
            case (state_q)
                HUNT: begin
                    if (prefix_hit) begin
                        state_d = GAP;
                        zcnt_d  = '0;
                    end
                end
                GAP: begin
                    zcnt_d  = '0;
                    state_d = prefix_hit ? GAP : HUNT;
                    if (!bus.sig_to_test) begin
                        // An open zero run outranks a fresh prefix seen at the same time.
                        if (int'(zcnt_q) < int'(MAX_ZEROS)) begin
                            zcnt_d  = zcnt_q + 1'b1;
                            state_d = GAP;
                        end
                    end else if (int'(zcnt_q) >= int'(MIN_ZEROS)) begin
                        detect = 1'b1;
                        if (!bus.overlap) begin
                            valid_d = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Ripple BCD increment; an all-nines count either holds or rolls to zero.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        if (all_nines && SATURATE) count_inc = count_q;
    end

    always_comb begin
        count_d = count_q;
        if (bus.clr_count) begin
            count_d = '0;
        end else if (detect) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            hist_q  <= '0;
            valid_q <= '0;
            zcnt_q  <= '0;
            count_q <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            valid_q <= valid_d;
            zcnt_q  <= zcnt_d;
            count_q <= count_d;
            z_q     <= detect;
        end
    end

    assign bus.z            = z_q;
    assign bus.count_detect = count_q;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_to_7seg u_seg (
            .bcd (count_q[4*g +: 4]),
            .seg (bus.disp[8*g +: 8])
        );
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed 01[0*]1 detector.
- Serial input is matched against PREFIX, then a run of k zeros with MIN_ZEROS <= k <= MAX_ZEROS, then a single 1.
- Each match pulses a flag and increments a DIGITS-wide BCD counter driving active-low 7-segment outputs.
- Overlapping or non-overlapping matching is selectable at runtime. The block sits between the board input synchroniser and the display pins.

Parameters:
- PREFIX_LEN, 2, number of prefix bits (>=1).
- PREFIX, 2'b01, prefix pattern; MSB is the oldest bit received.
- MIN_ZEROS, 0, minimum zero-run length accepted.
- MAX_ZEROS, 15, maximum zero-run length; a longer run aborts the match (>= MIN_ZEROS).
- DIGITS, 2, number of BCD counter digits.
- SATURATE, 1, counter policy at 9..9: 1 holds the value, 0 wraps to 0..0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  bit-valid qualifier; sig_to_test is sampled only when ena=1.
- sig_to_test  in  1  serial data bit.
- overlap  in  1  1 = bits of a detected match may seed the next prefix; 0 = history flushed after a detect.
- clr_count  in  1  synchronous clear of the counter only.
- z  out  1  registered one-cycle detect pulse.
- count_detect  out  4*DIGITS  BCD detect count; digit 0 in the LSBs.
- disp  out  8*DIGITS  per-digit segments {dp,g,f,e,d,c,b,a}, active-low, dp held at 1.

Behaviour:
- Reset (rst=1 at posedge): state=HUNT, history and valid count cleared, zero counter=0, z=0, count_detect=0.
  - disp per digit = 8'hC0 ("0").
  - rst overrides ena, clr_count and any in-flight match.
- History: PREFIX_LEN-bit shift register plus a valid count 0..PREFIX_LEN.
  - Shifts in sig_to_test on every ena=1 edge; valid saturates at PREFIX_LEN.
  - prefix_hit = (valid after shift == PREFIX_LEN) && (new history == PREFIX).
- ena=0: nothing changes; z drops to 0.
- HUNT, on ena=1: if prefix_hit, go to GAP with zcnt=0; else stay in HUNT.
- GAP, on ena=1 with bit=0:
  - If zcnt < MAX_ZEROS: zcnt++ and stay in GAP. Staying in GAP takes priority over prefix_hit.
  - If zcnt == MAX_ZEROS: abort. Go to GAP (zcnt=0) if prefix_hit, else to HUNT.
- GAP, on ena=1 with bit=1:
  - If zcnt >= MIN_ZEROS: detect. z=1 in the next cycle and the counter increments on the same edge.
  - If zcnt < MIN_ZEROS: no detect.
  - Next state after a detect:
    - overlap=1: prefix_hit is evaluated on the new history; go to GAP (zcnt=0) or HUNT.
    - overlap=0: history valid count is cleared to 0 and the next state is HUNT.
  - Next state without a detect: go to GAP (zcnt=0) if prefix_hit, else to HUNT.
- Latency: the detect bit is sampled at edge N; z is high for cycle N to N+1 only. Back-to-back detects give consecutive z pulses.
- Counter: BCD ripple increment with per-digit carry.
  - At all-nines: SATURATE=1 holds the value; SATURATE=0 wraps to 0.
  - clr_count=1 zeroes the counter; clear wins over a simultaneous increment, but z still pulses.
- disp is a combinational decode of the count_detect register. Codes 0-9 use the standard active-low table; the unreachable codes A-F display blank (8'hFF).
- zcnt width = $clog2(MAX_ZEROS+1); zcnt never exceeds MAX_ZEROS.

Decomposition:
- Package seq_detector_pkg: state enum (HUNT, GAP); 7-segment constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module bcd_to_7seg (4-bit BCD in, 8-bit active-low out), instantiated DIGITS times in a generate loop.

Test Plan:
- Defaults, overlap=1, stream 0,1,1 → z pulses once, the cycle after the third bit; count_detect=8'h01; disp[7:0]=8'hF9.
- Defaults, stream 0,1,0,1,0,1:
  - overlap=1 → 2 z pulses, count=8'h02.
  - Repeat after rst with overlap=0 → 1 pulse, count=8'h01.
- MAX_ZEROS=3, stream 0,1,0,0,0,0,1 → no z, count=8'h00. The final 1 re-arms via prefix "01"; a following 1 then gives z and count=8'h01.
- MIN_ZEROS=2, stream 0,1,0,1 → no z; stream 0,1,0,0,1 → z, count=8'h01.
- Counter boundaries:
  - 99 detects then 1 more: SATURATE=1 → count=8'h99, disp=16'h9090; SATURATE=0 → count=8'h00.
  - clr_count asserted on a detect edge → count=0 while z still pulses.
- Reset and ena:
  - Stream 0,1,0, then rst for 1 cycle, then 1 → no z; all outputs at reset values.
  - ena=0 for 5 cycles mid-GAP → state, zcnt and count unchanged.
